// File: rtl/dragon_spawn_ctrl.sv
// -----------------------------------------------------------------------------
// dragon_spawn_ctrl
//
// Scheduler and lifecycle controller for a pool of four dragon enemy slots.
// A gap timer spaces spawns out. Each spawn goes to the first IDLE slot,
// searching round-robin from rr_ptr. The spawn position comes from an
// internal 10-bit LFSR. Each slot then runs IDLE -> ACTIVE -> (DYING) ->
// COOL -> IDLE. Hits on ACTIVE slots are counted in a saturating kill counter.
//
// Ports
//   clk_22_i       game tick clock
//   rst_ni         asynchronous active-low reset
//   enable_i       game running; low freezes every register except spawn_valid
//   seed_i[9:0]    LFSR seed, loaded while reset is asserted (0 maps to 1)
//   hit_i[3:0]     per-slot: dragon struck this cycle
//   offscreen_i[3:0] per-slot: dragon touched a board edge
//   spawn_valid_o  one-cycle pulse, a slot was just spawned
//   spawn_id_o     slot index of that spawn
//   spawn_x_o/y_o  spawn position, valid with spawn_valid_o
//   alive_o[3:0]   slot is ACTIVE
//   dying_o[3:0]   slot is DYING
//   kill_cnt_o     saturating kill counter
// -----------------------------------------------------------------------------
module dragon_spawn_ctrl #(
    parameter int SPAWN_GAP   = 40,
    parameter int DYING_TICKS = 8,
    parameter int COOLDOWN    = 100,
    parameter int X_BASE      = 450,
    parameter int X_RANGE     = 200,
    parameter int Y_BASE      = 160,
    parameter int Y_RANGE     = 320
) (
    input  logic       clk_22_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [9:0] seed_i,
    input  logic [3:0] hit_i,
    input  logic [3:0] offscreen_i,
    output logic       spawn_valid_o,
    output logic [1:0] spawn_id_o,
    output logic [9:0] spawn_x_o,
    output logic [9:0] spawn_y_o,
    output logic [3:0] alive_o,
    output logic [3:0] dying_o,
    output logic [7:0] kill_cnt_o
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DYING  = 2'd2;
    localparam logic [1:0] ST_COOL   = 2'd3;

    localparam int GAP_W = (SPAWN_GAP < 1) ? 1 : $clog2(SPAWN_GAP + 1);
    localparam logic [GAP_W-1:0] GAP_MAX    = GAP_W'(SPAWN_GAP);
    localparam logic [6:0]       DYING_LAST = 7'(DYING_TICKS - 1);
    localparam logic [6:0]       COOL_LAST  = 7'(COOLDOWN - 1);

    logic [9:0]       lfsr_q;
    logic [GAP_W-1:0] gap_q;
    logic [1:0]       rr_ptr_q;
    logic [7:0]       kill_cnt_q;
    logic             spawn_valid_q;
    logic [1:0]       spawn_id_q;
    logic [9:0]       spawn_x_q;
    logic [9:0]       spawn_y_q;

    logic [3:0]       idle_vec;
    logic [3:0]       kill_ev;
    logic             found;
    logic [1:0]       chosen;
    logic [1:0]       idx;
    logic             spawn_fire;
    logic [9:0]       lfsr_d;
    logic [9:0]       y_rot;
    logic [31:0]      x_full;
    logic [31:0]      y_full;
    logic [GAP_W-1:0] gap_d;
    logic [2:0]       kill_num;
    logic [8:0]       kill_sum;
    logic [7:0]       kill_cnt_d;

    // First IDLE slot at or after rr_ptr, wrapping modulo 4.
    always_comb begin
        found  = 1'b0;
        chosen = rr_ptr_q;
        idx    = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr_q + 2'(k);
            if (!found && idle_vec[idx]) begin
                found  = 1'b1;
                chosen = idx;
            end
        end
    end

    assign spawn_fire = enable_i && found && (gap_q == GAP_MAX);

    // The position uses the LFSR value from before the spawning edge.
    assign lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    assign y_rot  = {lfsr_q[4:0], lfsr_q[9:5]};
    assign x_full = 32'(X_BASE) + (32'(lfsr_q) % 32'(X_RANGE));
    assign y_full = 32'(Y_BASE) + (32'(y_rot) % 32'(Y_RANGE));

    always_comb begin
        gap_d = gap_q;
        if (spawn_fire)
            gap_d = '0;
        else if (gap_q < GAP_MAX)
            gap_d = gap_q + 1'b1;
    end

    // Hits in several slots on one edge each count as a kill.
    always_comb begin
        kill_num = 3'd0;
        for (int k = 0; k < 4; k++)
            kill_num = kill_num + {2'b00, kill_ev[k]};
        kill_sum   = {1'b0, kill_cnt_q} + {6'd0, kill_num};
        kill_cnt_d = kill_sum[8] ? 8'hFF : kill_sum[7:0];
    end

    always_ff @(posedge clk_22_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q        <= (seed_i == 10'd0) ? 10'h001 : seed_i;
            gap_q         <= '0;
            rr_ptr_q      <= 2'd0;
            kill_cnt_q    <= 8'd0;
            spawn_valid_q <= 1'b0;
            spawn_id_q    <= 2'd0;
            spawn_x_q     <= 10'd0;
            spawn_y_q     <= 10'd0;
        end else if (enable_i) begin
            lfsr_q        <= lfsr_d;
            gap_q         <= gap_d;
            kill_cnt_q    <= kill_cnt_d;
            spawn_valid_q <= spawn_fire;
            if (spawn_fire) begin
                rr_ptr_q   <= chosen + 2'd1;
                spawn_id_q <= chosen;
                spawn_x_q  <= x_full[9:0];
                spawn_y_q  <= y_full[9:0];
            end
        end else begin
            spawn_valid_q <= 1'b0;
        end
    end

    // Per-slot lifecycle FSM.
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        logic [1:0] state_q, state_d;
        logic [6:0] cnt_q, cnt_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_IDLE: begin
                    if (spawn_fire && (chosen == 2'(gi)))
                        state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    // A hit wins over offscreen on the same edge.
                    if (hit_i[gi]) begin
                        state_d = ST_DYING;
                        cnt_d   = 7'd0;
                    end else if (offscreen_i[gi]) begin
                        state_d = ST_COOL;
                        cnt_d   = 7'd0;
                    end
                end
                ST_DYING: begin
                    if (cnt_q == DYING_LAST) begin
                        state_d = ST_COOL;
                        cnt_d   = 7'd0;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
                default: begin
                    if (cnt_q == COOL_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = 7'd0;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            endcase
        end

        always_ff @(posedge clk_22_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= ST_IDLE;
                cnt_q   <= 7'd0;
            end else if (enable_i) begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign idle_vec[gi] = (state_q == ST_IDLE);
        assign alive_o[gi]  = (state_q == ST_ACTIVE);
        assign dying_o[gi]  = (state_q == ST_DYING);
        assign kill_ev[gi]  = (state_q == ST_ACTIVE) && hit_i[gi];
    end

    assign spawn_valid_o = spawn_valid_q;
    assign spawn_id_o    = spawn_id_q;
    assign spawn_x_o     = spawn_x_q;
    assign spawn_y_o     = spawn_y_q;
    assign kill_cnt_o    = kill_cnt_q;

endmodule
